// File: rtl/prog_boot_ctrl_pkg.sv
// Shared types and constants for the program loader / test sequencer.
package prog_boot_pkg;

  // Loader / run sequencer states
  typedef enum logic [2:0] {
    IDLE,
    LEN,
    LOAD,
    HOLD,
    RUN,
    DONE
  } boot_state_t;

  // Value a program stores to tohost to signal success
  localparam logic [31:0] PASS_CODE = 32'd1;

  // The image header is a 4-byte little-endian word count
  localparam int HDR_BYTES = 4;

endpackage

// File: rtl/prog_boot_ctrl_if.sv
// Byte stream, instruction-memory write port, data-memory snoop and run status
// of the program loader, bundled so the controller and its surroundings share
// one set of wires.
interface prog_boot_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              core_rst_n;
  logic              dmem_we;
  logic [31:0]       dmem_addr;
  logic [31:0]       dmem_wdata;
  logic              done;
  logic              pass;
  logic              timed_out;
  logic              len_err;
  logic [31:0]       result;

  // System side: supplies bytes and core stores, observes loader results
  modport master (
    output start, rx_valid, rx_data, dmem_we, dmem_addr, dmem_wdata,
    input  rx_ready, imem_we, imem_addr, imem_wdata, core_rst_n,
           done, pass, timed_out, len_err, result
  );

  // Controller side
  modport slave (
    input  start, rx_valid, rx_data, dmem_we, dmem_addr, dmem_wdata,
    output rx_ready, imem_we, imem_addr, imem_wdata, core_rst_n,
           done, pass, timed_out, len_err, result
  );
endinterface

// File: rtl/prog_boot_ctrl_byte_packer.sv
// Little-endian byte-to-word assembler. The first byte received lands in the
// least significant position; word/word_valid are presented combinationally
// in the same cycle the final byte is accepted.
module byte_packer #(
  parameter int BYTES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic [BYTES*8-1:0] word,
  output logic               word_valid
);
  localparam int W     = BYTES * 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [CNT_W-1:0] byte_cnt;

  assign word_valid = byte_valid && (byte_cnt == CNT_W'(BYTES - 1));

  // Count accepted bytes, wrapping to zero once a full word has been seen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      byte_cnt <= '0;
    else if (clr)
      byte_cnt <= '0;
    else if (byte_valid)
      byte_cnt <= word_valid ? '0 : byte_cnt + CNT_W'(1);
  end

  generate
    if (BYTES == 1) begin : g_single
      assign word = byte_data;
    end else begin : g_multi
      logic [W-9:0] shift_q;

      assign word = {byte_data, shift_q};

      // New bytes enter at the top and older bytes slide toward bit 0
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          shift_q <= '0;
        else if (byte_valid)
          shift_q <= word[W-1:8];
      end
    end
  endgenerate

endmodule

// File: rtl/prog_boot_ctrl.sv
// Program loader and test sequencer: streams an image into instruction memory,
// holds the core in reset while loading, releases it, then ends the run on a
// tohost store or when the cycle budget is exhausted.
module prog_boot_ctrl
  import prog_boot_pkg::*;
#(
  parameter int          ADDR_W      = 12,
  parameter int          DATA_W      = 32,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
  parameter int          TIMEOUT     = 100000,
  parameter int          HOLD_CYC    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  prog_boot_ctrl_if.slave       bus
);
  localparam int          CNT_W  = $clog2(TIMEOUT + 1);
  localparam int          HOLD_W = $clog2(HOLD_CYC + 1);
  localparam logic [32:0] DEPTH  = 33'd1 << ADDR_W;

  boot_state_t       state, next_state;
  logic [31:0]       hdr_word;
  logic              hdr_valid;
  logic [DATA_W-1:0] pay_word;
  logic              pay_valid;
  logic [ADDR_W:0]   word_idx;
  logic [ADDR_W:0]   len_words;
  logic [CNT_W-1:0]  cyc_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              start_acc;
  logic              too_long;
  logic              last_word;
  logic              tohost_hit;
  logic              run_expire;
  logic              hold_expire;

  assign start_acc   = bus.start && ((state == IDLE) || (state == DONE));
  assign too_long    = {1'b0, hdr_word} > DEPTH;
  assign last_word   = (word_idx + (ADDR_W + 1)'(1)) == len_words;
  assign tohost_hit  = (state == RUN) && bus.dmem_we && (bus.dmem_addr == TOHOST_ADDR);
  assign run_expire  = (state == RUN) && (cyc_cnt == CNT_W'(TIMEOUT - 1));
  assign hold_expire = hold_cnt == HOLD_W'(HOLD_CYC - 1);

  assign bus.rx_ready   = (state == LEN) || (state == LOAD);
  assign bus.core_rst_n = (state == RUN);
  assign bus.done       = (state == DONE);

  byte_packer #(.BYTES(HDR_BYTES)) u_hdr_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (start_acc),
    .byte_valid (bus.rx_valid && (state == LEN)),
    .byte_data  (bus.rx_data),
    .word       (hdr_word),
    .word_valid (hdr_valid)
  );

  byte_packer #(.BYTES(DATA_W / 8)) u_pay_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (start_acc),
    .byte_valid (bus.rx_valid && (state == LOAD)),
    .byte_data  (bus.rx_data),
    .word       (pay_word),
    .word_valid (pay_valid)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Sequencing: header, payload, reset hold, run, then wait for re-arm
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start_acc) next_state = LEN;
      LEN: begin
        if (hdr_valid) begin
          if (hdr_word == 32'd0)
            next_state = HOLD;
          else if (too_long)
            next_state = DONE;
          else
            next_state = LOAD;
        end
      end
      LOAD: if (pay_valid && last_word) next_state = HOLD;
      HOLD: if (hold_expire) next_state = RUN;
      RUN:  if (tohost_hit || run_expire) next_state = DONE;
      DONE: if (start_acc) next_state = LEN;
      default: next_state = IDLE;
    endcase
  end

  // Memory write port, counters and latched run status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      bus.pass       <= 1'b0;
      bus.timed_out  <= 1'b0;
      bus.len_err    <= 1'b0;
      bus.result     <= '0;
      word_idx       <= '0;
      len_words      <= '0;
      cyc_cnt        <= '0;
      hold_cnt       <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      if (start_acc) begin
        word_idx      <= '0;
        bus.pass      <= 1'b0;
        bus.timed_out <= 1'b0;
        bus.len_err   <= 1'b0;
        bus.result    <= '0;
      end
      if ((state == LEN) && hdr_valid) begin
        len_words <= hdr_word[ADDR_W:0];
        word_idx  <= '0;
        if (too_long)
          bus.len_err <= 1'b1;
      end
      if ((state == LOAD) && pay_valid) begin
        bus.imem_we    <= 1'b1;
        bus.imem_addr  <= word_idx[ADDR_W-1:0];
        bus.imem_wdata <= pay_word;
        word_idx       <= word_idx + (ADDR_W + 1)'(1);
      end
      hold_cnt <= (state == HOLD) ? hold_cnt + HOLD_W'(1) : '0;
      cyc_cnt  <= (state == RUN) ? cyc_cnt + CNT_W'(1) : '0;
      if (tohost_hit) begin
        bus.result <= bus.dmem_wdata;
        bus.pass   <= (bus.dmem_wdata == PASS_CODE);
      end else if (run_expire) begin
        bus.timed_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prog_boot_ctrl.sv
// Directed testbench for prog_boot_ctrl with a queue-style scoreboard:
// stimulus tasks record expected memory writes and run outcomes, and a
// negedge monitor compares them against what the controller presents.
module tb_prog_boot_ctrl;
  import prog_boot_pkg::*;

  localparam int          ADDR_W   = 4;
  localparam int          DATA_W   = 32;
  localparam int          TIMEOUT  = 50;
  localparam int          HOLD_CYC = 4;
  localparam logic [31:0] TOHOST   = 32'h0000_1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  // Free-running clock
  always #5 clk = ~clk;

  prog_boot_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  prog_boot_ctrl #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TOHOST_ADDR (TOHOST),
    .TIMEOUT     (TIMEOUT),
    .HOLD_CYC    (HOLD_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_exp_t;

  typedef struct packed {
    logic        pass;
    logic        timed_out;
    logic        len_err;
    logic [31:0] result;
    logic        chk_hold;
    logic        chk_store;
    logic [1:0]  rises;
  } dn_exp_t;

  wr_exp_t     wr_exp [64];
  dn_exp_t     dn_exp [16];
  int          wr_tail    = 0;
  int          dn_tail    = 0;
  logic        finish_req = 1'b0;
  logic [31:0] img [16];

  int   cyc         = 0;
  int   wr_head     = 0;
  int   dn_head     = 0;
  int   total       = 0;
  int   bad         = 0;
  int   rise_cnt    = 0;
  int   rise_cyc    = 0;
  int   last_wr_cyc = 0;
  int   store_cyc   = 0;
  logic prev_rst    = 1'b1;
  logic prev_core   = 1'b0;
  logic prev_done   = 1'b0;

  // Cycle stamp for latency measurements
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: reset state, memory writes, core release and run completion
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      if (prev_rst) begin
        checkOutput("rst_rx_ready",   32'(bus.rx_ready),   32'd0);
        checkOutput("rst_imem_we",    32'(bus.imem_we),    32'd0);
        checkOutput("rst_core_rst_n", 32'(bus.core_rst_n), 32'd0);
        checkOutput("rst_done",       32'(bus.done),       32'd0);
        checkOutput("rst_pass",       32'(bus.pass),       32'd0);
        checkOutput("rst_timed_out",  32'(bus.timed_out),  32'd0);
        checkOutput("rst_len_err",    32'(bus.len_err),    32'd0);
        checkOutput("rst_result",     bus.result,          32'd0);
      end
      prev_core = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (bus.start) rise_cnt = 0;
      if (bus.imem_we) begin
        if (wr_head >= wr_tail) begin
          checkOutput("write_expected", 32'(wr_tail - wr_head), 32'd1);
        end else begin
          checkOutput("wr_addr", 32'(bus.imem_addr), 32'(wr_exp[wr_head].addr));
          checkOutput("wr_data", bus.imem_wdata, wr_exp[wr_head].data);
          wr_head++;
        end
        last_wr_cyc = cyc;
      end
      if (bus.dmem_we && bus.dmem_addr == TOHOST) store_cyc = cyc;
      if (bus.core_rst_n && !prev_core) begin
        rise_cnt++;
        rise_cyc = cyc;
      end
      if (bus.done && !prev_done) begin
        if (dn_head >= dn_tail) begin
          checkOutput("done_expected", 32'(dn_tail - dn_head), 32'd1);
        end else begin
          dn_exp_t e;
          e = dn_exp[dn_head];
          dn_head++;
          checkOutput("pass",        32'(bus.pass),       32'(e.pass));
          checkOutput("timed_out",   32'(bus.timed_out),  32'(e.timed_out));
          checkOutput("len_err",     32'(bus.len_err),    32'(e.len_err));
          checkOutput("result",      bus.result,          e.result);
          checkOutput("core_in_rst", 32'(bus.core_rst_n), 32'd0);
          checkOutput("core_rises",  32'(rise_cnt),       32'(e.rises));
          if (e.chk_hold)  checkOutput("hold_cycles",  32'(rise_cyc - last_wr_cyc), 32'(HOLD_CYC));
          if (e.timed_out) checkOutput("run_cycles",   32'(cyc - rise_cyc),         32'(TIMEOUT));
          if (e.chk_store) checkOutput("done_latency", 32'(cyc - store_cyc),        32'd1);
        end
      end
      prev_core = bus.core_rst_n;
      prev_done = bus.done;
      if (finish_req) begin
        checkOutput("writes_outstanding", 32'(wr_tail - wr_head), 32'd0);
        checkOutput("dones_outstanding",  32'(dn_tail - dn_head), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
    prev_rst = rst_n;
  end

  // Hard stop in case the stimulus itself wedges
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    logic acc;
    acc          = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      acc = bus.rx_ready;
      nextCycle();
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic sendWordBytes(input logic [31:0] w);
    for (int i = 0; i < 4; i++) sendByte(8'(w >> (8 * i)));
  endtask

  task automatic loadWord(input int a, input logic [31:0] w);
    wr_exp[wr_tail] = '{addr: ADDR_W'(a), data: w};
    wr_tail++;
    sendWordBytes(w);
  endtask

  task automatic pulseStart();
    bus.start = 1'b1;
    nextCycle();
    bus.start = 1'b0;
  endtask

  task automatic pushDone(input logic p, input logic to, input logic le, input logic [31:0] r,
                          input logic ch, input logic cs, input logic [1:0] rises);
    dn_exp[dn_tail] = '{pass: p, timed_out: to, len_err: le, result: r,
                        chk_hold: ch, chk_store: cs, rises: rises};
    dn_tail++;
  endtask

  task automatic waitCore();
    for (int k = 0; k < 200 && !bus.core_rst_n; k++) nextCycle();
  endtask

  task automatic waitDone();
    for (int k = 0; k < 300 && !bus.done; k++) nextCycle();
    nextCycle();
  endtask

  task automatic storeTohost(input logic [31:0] a, input logic [31:0] d);
    bus.dmem_we    = 1'b1;
    bus.dmem_addr  = a;
    bus.dmem_wdata = d;
    nextCycle();
    bus.dmem_we    = 1'b0;
  endtask

  task automatic applyStimulus(input int n_hdr, input int n_words);
    pulseStart();
    sendWordBytes(32'(n_hdr));
    for (int i = 0; i < n_words; i++) loadWord(i, img[i]);
  endtask

  // Directed scenarios
  initial begin
    bus.start      = 1'b0;
    bus.rx_valid   = 1'b0;
    bus.rx_data    = 8'h00;
    bus.dmem_we    = 1'b0;
    bus.dmem_addr  = 32'h0;
    bus.dmem_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    nextCycle();

    $display("[TB] three-word image, tohost pass");
    img[0] = 32'h0000_0013; img[1] = 32'h0010_0093; img[2] = 32'h0000_8067;
    pushDone(1'b1, 1'b0, 1'b0, 32'd1, 1'b1, 1'b1, 2'd1);
    applyStimulus(3, 3);
    waitCore();
    repeat (3) nextCycle();
    storeTohost(TOHOST, PASS_CODE);
    waitDone();

    $display("[TB] one-word image, tohost fail code");
    img[0] = 32'hDEAD_BEEF;
    pushDone(1'b0, 1'b0, 1'b0, 32'd7, 1'b1, 1'b1, 2'd1);
    applyStimulus(1, 1);
    waitCore();
    storeTohost(32'h0000_1004, PASS_CODE);
    nextCycle();
    storeTohost(TOHOST, 32'd7);
    waitDone();

    $display("[TB] timeout");
    img[0] = 32'h1234_0001; img[1] = 32'h1234_0002;
    pushDone(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 2'd1);
    applyStimulus(2, 2);
    waitDone();

    $display("[TB] empty image");
    pushDone(1'b1, 1'b0, 1'b0, 32'd1, 1'b0, 1'b1, 2'd1);
    applyStimulus(0, 0);
    waitCore();
    storeTohost(TOHOST, PASS_CODE);
    waitDone();

    $display("[TB] oversize header");
    pushDone(1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 2'd0);
    applyStimulus(17, 0);
    waitDone();
    repeat (10) nextCycle();

    $display("[TB] full-depth image");
    for (int i = 0; i < 16; i++) img[i] = 32'hA000_0000 + 32'(i * 32'h0101_0101);
    pushDone(1'b1, 1'b0, 1'b0, 32'd1, 1'b1, 1'b1, 2'd1);
    applyStimulus(16, 16);
    waitCore();
    storeTohost(TOHOST, PASS_CODE);
    waitDone();

    $display("[TB] stalled stream mid-word");
    pushDone(1'b1, 1'b0, 1'b0, 32'd1, 1'b1, 1'b1, 2'd1);
    pulseStart();
    sendWordBytes(32'd2);
    loadWord(0, 32'hA5A5_5A5A);
    wr_exp[wr_tail] = '{addr: ADDR_W'(1), data: 32'h1234_5678};
    wr_tail++;
    sendByte(8'h78);
    sendByte(8'h56);
    repeat (5) nextCycle();
    pulseStart();
    repeat (5) nextCycle();
    sendByte(8'h34);
    sendByte(8'h12);
    waitCore();
    storeTohost(TOHOST, PASS_CODE);
    waitDone();

    $display("[TB] reset during load, then reload");
    pulseStart();
    sendWordBytes(32'd3);
    loadWord(0, 32'h1111_1111);
    sendByte(8'h22);
    sendByte(8'h22);
    rst_n = 1'b0;
    repeat (3) nextCycle();
    rst_n = 1'b1;
    nextCycle();
    img[0] = 32'hCAFE_0000; img[1] = 32'hCAFE_0001; img[2] = 32'hCAFE_0002;
    pushDone(1'b1, 1'b0, 1'b0, 32'd1, 1'b1, 1'b1, 2'd1);
    applyStimulus(3, 3);
    waitCore();
    storeTohost(TOHOST, PASS_CODE);
    waitDone();

    repeat (2) nextCycle();
    finish_req = 1'b1;
    repeat (5) nextCycle();
  end

endmodule
